// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bus of the load/store unit.
// master = issuing pipeline, slave = load_store_unit.
interface load_store_unit_if;
   logic        req_valid_i;
   logic        req_wen_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        req_ready_o;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;

   modport master (
      output req_valid_i, req_wen_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   modport slave (
      input  req_valid_i, req_wen_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits byte/half/word accesses into single-byte cache
// transactions, assembles load data and returns one extended response.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned halves/words and
// the reserved size are rejected with resp_err_o instead of executing.
package mem_pkg;
   typedef struct packed {
      logic        Valid;
      logic        Wen;
      logic [31:0] Addr;
      logic [7:0]  ByteData;
   } CInput;

   typedef struct packed {
      logic       Ready;
      logic [7:0] ByteOut;
   } COutput;
endpackage

module load_store_unit
   import mem_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   load_store_unit_if.slave     lsu,
   output CInput                cache_o,
   input  COutput               cache_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q;
   logic        wen_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;

   logic        accept;
   logic        byte_done;
   logic [1:0]  last_idx;
   logic        trap;
   logic [31:0] ext_data;

   assign accept    = (state_q == IDLE) && lsu.req_valid_i;
   assign byte_done = (state_q == ACCESS) && cache_i.Ready;

   // Index of the final byte; the reserved size runs as a word when not trapped.
   always_comb begin
      last_idx = 2'd3;
      case (size_q)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q;

   // Decode misalignment from the live request so the trap decision is made at accept.
   assign trap = ((lsu.req_size_i == 2'b01) && lsu.req_addr_i[0])
              || ((lsu.req_size_i == 2'b10) && (lsu.req_addr_i[1:0] != 2'b00))
              ||  (lsu.req_size_i == 2'b11);
`else
   assign trap = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: trapped requests skip the cache and go straight to RESP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (lsu.req_valid_i) state_d = trap ? RESP : ACCESS;
         ACCESS:  if (byte_done && (cnt_q == last_idx)) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, byte counter and read buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= 2'd0;
         wen_q   <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         buf_q   <= 32'd0;
      end else if (accept) begin
         cnt_q   <= 2'd0;
         wen_q   <= lsu.req_wen_i;
         size_q  <= lsu.req_size_i;
         uns_q   <= lsu.req_unsigned_i;
         addr_q  <= lsu.req_addr_i;
         wdata_q <= lsu.req_wdata_i;
         buf_q   <= 32'd0;
      end else if (byte_done) begin
         if (!wen_q) buf_q[{cnt_q, 3'b000} +: 8] <= cache_i.ByteOut;
         if (cnt_q != last_idx) cnt_q <= cnt_q + 2'd1;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   // Error flag follows the request through to its RESP cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)      err_q <= 1'b0;
      else if (accept) err_q <= trap;
   end
`endif

   // Sign/zero extension of the assembled load data.
   always_comb begin
      ext_data = buf_q;
      case (size_q)
         2'b00:   ext_data = uns_q ? {24'd0, buf_q[7:0]}  : {{24{buf_q[7]}},  buf_q[7:0]};
         2'b01:   ext_data = uns_q ? {16'd0, buf_q[15:0]} : {{16{buf_q[15]}}, buf_q[15:0]};
         default: ext_data = buf_q;
      endcase
   end

   // Cache port: only live in ACCESS; fields derive from latched state so they hold during stalls.
   always_comb begin
      cache_o          = '0;
      cache_o.Addr     = addr_q + {30'd0, cnt_q};
      if (state_q == ACCESS) begin
         cache_o.Valid    = 1'b1;
         cache_o.Wen      = wen_q;
         cache_o.ByteData = wen_q ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;
      end
   end

   assign lsu.req_ready_o  = (state_q == IDLE);
   assign lsu.resp_valid_o = (state_q == RESP);

`ifdef LSU_MISALIGN_TRAP_EN
   assign lsu.resp_err_o   = (state_q == RESP) && err_q;
   assign lsu.resp_rdata_o = ((state_q == RESP) && !wen_q && !err_q) ? ext_data : 32'd0;
`else
   assign lsu.resp_err_o   = 1'b0;
   assign lsu.resp_rdata_o = ((state_q == RESP) && !wen_q) ? ext_data : 32'd0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-addressed memory model predicts
// every cache byte transaction and every response; a negedge monitor compares.
module tb_load_store_unit;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if bus();
   CInput  cache_o;
   COutput cache_i;

   load_store_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .lsu     (bus),
      .cache_o (cache_o),
      .cache_i (cache_i)
   );

   typedef struct packed {logic wen; logic [31:0] addr; logic [7:0] data;} cexp_t;
   typedef struct packed {logic [31:0] rdata; logic err;} rexp_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   cexp_t exp_cache[$];
   rexp_t exp_resp[$];
   logic [7:0] cmem [logic [31:0]];   // memory as the cache sees it (written by DUT stores)
   logic [7:0] rmem [logic [31:0]];   // reference memory updated at issue time
   int rdy_mode = 0;                  // 0 always ready, 1 random, 2 three-cycle stall per byte
   int stall_cnt = 0;
   int resp_cnt = 0;
   int resp_cyc = 0;
   logic [31:0] last_rdata = 32'd0;
   bit prev_stall = 0;
   CInput held;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] cread(input logic [31:0] a);
      return cmem.exists(a) ? cmem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] rread(input logic [31:0] a);
      return rmem.exists(a) ? rmem[a] : init_byte(a);
   endfunction

   task automatic fail(input string nm, input string msg);
      total++;
      bad++;
      $display("FAIL %s: %s", nm, msg);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (cache_o.Valid && cache_i.Ready) stall_cnt <= 0;
      else if (cache_o.Valid)             stall_cnt <= stall_cnt + 1;
      else                                stall_cnt <= 0;
   end

   // Cache responder and monitor: Ready decided here holds through the next posedge.
   always @(negedge clk) begin
      logic r;
      cexp_t ce;
      rexp_t re;
      case (rdy_mode)
         0:       r = 1'b1;
         1:       r = ($urandom_range(0, 2) != 0);
         default: r = (stall_cnt >= 3);
      endcase
      cache_i.Ready   = r;
      cache_i.ByteOut = cread(cache_o.Addr);
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) chk("hold_fields", 64'(cache_o), 64'(held));
         if (cache_o.Valid) begin
            chk("ready_low_in_access", bus.req_ready_o, 0);
            if (r) begin
               prev_stall = 0;
               if (exp_cache.size() == 0) fail("cache_spurious", $sformatf("addr %0h", cache_o.Addr));
               else begin
                  ce = exp_cache.pop_front();
                  chk("cache_wen",  cache_o.Wen, ce.wen);
                  chk("cache_addr", cache_o.Addr, ce.addr);
                  chk("cache_data", cache_o.ByteData, ce.data);
               end
               if (cache_o.Wen) cmem[cache_o.Addr] = cache_o.ByteData;
            end else begin
               prev_stall = 1;
               held = cache_o;
            end
         end else begin
            prev_stall = 0;
         end
         if (bus.resp_valid_o) begin
            chk("ready_low_in_resp", bus.req_ready_o, 0);
            resp_cnt++;
            resp_cyc = cyc;
            last_rdata = bus.resp_rdata_o;
            if (exp_resp.size() == 0) fail("resp_spurious", $sformatf("rdata %0h", bus.resp_rdata_o));
            else begin
               re = exp_resp.pop_front();
               chk("resp_rdata", bus.resp_rdata_o, re.rdata);
               chk("resp_err",   bus.resp_err_o, re.err);
            end
         end
      end
   end

   // Reference model: byte list and extended result straight from the access rules.
   task automatic model(input bit wen, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int nb;
      logic [31:0] v = 32'd0;
      logic [31:0] a;
      bit trap = 0;
      rexp_t re;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) || (size == 2'b11);
`endif
      if (trap) begin
         re.rdata = 32'd0;
         re.err   = 1'b1;
         exp_resp.push_back(re);
         return;
      end
      nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++) begin
         a = addr + 32'(i);
         if (wen) begin
            exp_cache.push_back({1'b1, a, wdata[8*i +: 8]});
            rmem[a] = wdata[8*i +: 8];
         end else begin
            exp_cache.push_back({1'b0, a, 8'h00});
            v[8*i +: 8] = rread(a);
         end
      end
      if (nb == 1)      v = uns ? (v & 32'hFF)   : (v[7]  ? (v | 32'hFFFF_FF00) : v);
      else if (nb == 2) v = uns ? (v & 32'hFFFF) : (v[15] ? (v | 32'hFFFF_0000) : v);
      re.rdata = wen ? 32'd0 : v;
      re.err   = 1'b0;
      exp_resp.push_back(re);
   endtask

   // Present a request (called at posedge+1) and wait for acceptance.
   task automatic issue(input bit wen, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output int acc_cyc);
      bit got = 0;
      bus.req_valid_i    = 1'b1;
      bus.req_wen_i      = wen;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
      acc_cyc = -1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bus.req_ready_o) begin got = 1; break; end
      end
      if (!got) fail("accept_timeout", "req_ready_o never seen");
      else begin
         acc_cyc = cyc;
         model(wen, size, uns, addr, wdata);
      end
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int t = 0; t < 500; t++) begin
         @(posedge clk);
         #1;
         if (exp_resp.size() == 0 && exp_cache.size() == 0) begin ok = 1; break; end
      end
      if (!ok) fail("done_timeout", $sformatf("resp left %0d cache left %0d", exp_resp.size(), exp_cache.size()));
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      cmem[a] = d;
      rmem[a] = d;
   endtask

   initial begin
      int acc, acc_b, rc;
      bit ok;
      bus.req_valid_i = 1'b0; bus.req_wen_i = 1'b0; bus.req_size_i = 2'b00;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'd0; bus.req_wdata_i = 32'd0;
      cache_i = '0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cache_valid", cache_o.Valid, 0);
      chk("rst_cache_wen",   cache_o.Wen, 0);
      chk("rst_resp_valid",  bus.resp_valid_o, 0);
      chk("rst_resp_err",    bus.resp_err_o, 0);
      chk("rst_resp_rdata",  bus.resp_rdata_o, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", bus.req_ready_o, 1);
      @(posedge clk); #1;

      // Word store with always-ready cache
      rdy_mode = 0;
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, acc);
      wait_done();
      chk("store_latency", resp_cyc - acc, 5);
      chk("store_rdata", last_rdata, 32'h0);
      chk("store_b0", cread(32'h100), 8'hEF);
      chk("store_b1", cread(32'h101), 8'hBE);
      chk("store_b2", cread(32'h102), 8'hAD);
      chk("store_b3", cread(32'h103), 8'hDE);

      // Signed and unsigned byte loads of 0x80
      preload(32'h100, 8'h80);
      issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b0, acc);
      wait_done();
      chk("byte_latency", resp_cyc - acc, 2);
      chk("lb_signed", last_rdata, 32'hFFFF_FF80);
      issue(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 1'b0, acc);
      wait_done();
      chk("lb_unsigned", last_rdata, 32'h0000_0080);

      // Block-crossing half load with 3-cycle stalls
      rdy_mode = 2;
      preload(32'h10F, 8'h34);
      preload(32'h110, 8'h12);
      issue(1'b0, 2'b01, 1'b1, 32'h10F, 32'h0, 1'b0, acc);
      wait_done();
`ifndef LSU_MISALIGN_TRAP_EN
      chk("lh_cross", last_rdata, 32'h0000_1234);
      chk("lh_cross_latency", resp_cyc - acc, 9);
`endif

`ifdef LSU_MISALIGN_TRAP_EN
      // Misaligned word traps without touching the cache
      rdy_mode = 0;
      issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, acc);
      wait_done();
      chk("trap_latency", resp_cyc - acc, 1);
`endif

      // Back-to-back with req_valid_i held high; B fields change while A runs
      rdy_mode = 1;
      issue(1'b0, 2'b10, 1'b0, 32'h180, 32'h0, 1'b1, acc);
      issue(1'b1, 2'b00, 1'b0, 32'h181, 32'h0000_00A5, 1'b0, acc_b);
      chk("b2b_accept", acc_b, resp_cyc + 1);
      wait_done();

      // Reset during byte 2 of a word load
      rdy_mode = 0;
      issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, acc);
      ok = 0;
      for (int t = 0; t < 50; t++) begin
         if (exp_cache.size() <= 2) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) fail("mid_reset_wait", "byte 2 never reached");
      rst_n = 1'b0;
      exp_cache.delete();
      exp_resp.delete();
      rc = resp_cnt;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", cache_o.Valid, 0);
      chk("midrst_resp",  bus.resp_valid_o, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", bus.req_ready_o, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_no_resp", resp_cnt, rc);

      // Randomized traffic, including 32-bit address wrap
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         rdy_mode = $urandom_range(0, 2);
         a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                         : (32'h300 + 32'($urandom_range(0, 40)));
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom, 1'b0, acc);
         wait_done();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; the block is fixed at 32-bit address/data and a 1-byte cache port.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid_i  in  1  pipeline presents a load/store request.
REQ-005 req_wen_i  in  1  1 = store, 0 = load.
REQ-006 req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-008 req_addr_i  in  32  byte address of the lowest byte.
REQ-009 req_wdata_i  in  32  store data, byte k in bits [8k+7:8k].
REQ-010 req_ready_o  out  1  request accepted on a cycle with req_valid_i=1 and req_ready_o=1.
REQ-011 resp_valid_o  out  1  one-cycle pulse marking completion.
REQ-012 resp_rdata_o  out  32  extended load data; 0 for stores.
REQ-013 resp_err_o  out  1  misaligned/reserved-size error flag, valid with resp_valid_o.
REQ-014 cache_o  out  CInput (mem_pkg)  Valid, Wen, Addr[31:0], ByteData[7:0] to the cache.
REQ-015 cache_i  in  COutput (mem_pkg)  Ready, ByteOut[7:0] from the cache.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-017 IDLE: req_ready_o=1, cache_o.Valid=0; on req_valid_i=1, latch all req_* fields, clear byte counter, go to ACCESS.
REQ-018 Byte count N SHALL be 1/2/4 for size 00/01/10; size 11 without the trap feature SHALL be treated as 10.
REQ-019 ACCESS: cache_o.Valid=1, Addr = latched addr + counter (32-bit wrap at 0xFFFFFFFF), Wen = latched wen, ByteData = wdata byte[counter] for stores and 0 for loads.
REQ-020 cache_o fields SHALL stay constant until a posedge where cache_i.Ready=1; only then does the byte complete.
REQ-021 On a completing load byte, cache_i.ByteOut SHALL be captured into byte[counter] of the read buffer on that same edge.
REQ-022 On completion of byte counter = N-1, go to RESP; otherwise increment the counter and stay in ACCESS with Valid held high.
REQ-023 RESP: resp_valid_o=1 for exactly one cycle, cache_o.Valid=0, req_ready_o=0; next state IDLE.
REQ-024 resp_rdata_o SHALL be the buffer sign- or zero-extended from 8/16 bits per size/unsigned; full 32 bits for words; 0 for stores.
REQ-025 req_ready_o SHALL be 0 outside IDLE; req_* changes outside IDLE are ignored.
REQ-026 Minimum latency with an always-ready cache: word access accepted at cycle 0, bytes complete at cycles 1-4, resp_valid_o at cycle 5; byte access resp_valid_o at cycle 2.
REQ-027 Accesses crossing a 16-byte block boundary SHALL proceed byte-wise unchanged; the cache resolves each byte independently.
REQ-028 resp_err_o SHALL be 0 whenever the trap feature is compiled out.

Reset
REQ-029 rst_n=0 at a posedge SHALL force IDLE, clear counter and read buffer, and drive resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, cache_o.Valid=0, cache_o.Wen=0.
REQ-030 Reset mid-ACCESS SHALL abandon the transaction with no response; cache_o.Valid SHALL be 0 from the first cycle after the reset edge. Bytes already written by a store remain written.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN: when defined, a request with size 01 and addr[0]=1, size 10 and addr[1:0]!=0, or size 11 SHALL issue no cache access; it goes IDLE->RESP with resp_err_o=1 and resp_rdata_o=0.
REQ-032 When LSU_MISALIGN_TRAP_EN is undefined, misaligned requests SHALL execute byte-wise per REQ-019..REQ-027 and resp_err_o SHALL be tied 0.

Verification
REQ-033 Word store 0xDEADBEEF to 0x100 with an always-ready cache -> cache bytes EF,BE,AD,DE at 0x100-0x103, resp_valid_o at cycle 5, resp_rdata_o=0.
REQ-034 Signed byte load 0x100 where the cache returns 0x80 -> resp_rdata_o=0xFFFFFF80; the same load with unsigned=1 -> 0x00000080.
REQ-035 Half load at 0x10F (block crossing, trap off), cache Ready stalled 3 cycles per byte, bytes 0x34 then 0x12 -> cache_o fields held during each stall, resp_rdata_o=0x00001234.
REQ-036 Word load at 0x102 with LSU_MISALIGN_TRAP_EN defined -> cache_o.Valid never 1, resp_valid_o=1 and resp_err_o=1 at cycle 1.
REQ-037 rst_n=0 during byte 2 of a word load -> cache_o.Valid=0 on the next cycle, no resp_valid_o pulse, req_ready_o=1 after rst_n is released.
REQ-038 req_valid_i held high across back-to-back requests -> the second request is accepted only on the cycle after the RESP pulse.
